// File: rtl/led_panel_pkg.sv
// Shared types and defaults for the LED panel receive model.
package led_panel_pkg;

  localparam int COLS_DEF = 32;
  localparam int ROWS_DEF = 4;

  typedef struct packed {
    logic red;
    logic green;
    logic blue;
  } pixel_t;

  typedef enum logic {
    UNSYNC = 1'b0,
    RUN    = 1'b1
  } state_t;

endpackage

// File: rtl/led_pin_sync.sv
// Multi-flop synchronizer for one panel pin, with rise detect and a one-cycle-delayed level.
module led_pin_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset_n,
  input  logic pin_in,
  output logic level,
  output logic rise,
  output logic level_dly
);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   prev_q, prev_d;

  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], pin_in};
    prev_d = sync_q[SYNC_STAGES-1];
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= sync_d;
      prev_q <= prev_d;
    end
  end

  assign level     = sync_q[SYNC_STAGES-1];
  assign level_dly = prev_q;
  assign rise      = sync_q[SYNC_STAGES-1] & ~prev_q;

endmodule

// File: rtl/led_panel_sink.sv
// Panel-side model: captures serial rows into a frame store, tracks row address, flags bad rows.
// state  | meaning
// UNSYNC | waiting for first arst; shifts/latches ignored, row address still tracked
// RUN    | capturing rows into the frame store
module led_panel_sink
  import led_panel_pkg::*;
#(
  parameter int COLS        = COLS_DEF,
  parameter int ROWS        = ROWS_DEF,
  parameter int SYNC_STAGES = 2
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     sclk_in,
  input  logic                     latch_in,
  input  logic                     blank_in,
  input  logic                     aclk_in,
  input  logic                     arst_in,
  input  logic                     red_in,
  input  logic                     green_in,
  input  logic                     blue_in,
  input  logic [$clog2(ROWS)-1:0]  rd_row,
  input  logic [$clog2(COLS)-1:0]  rd_col,
  output logic [2:0]               rd_pixel,
  output logic [$clog2(ROWS)-1:0]  cur_row,
  output logic                     lit,
  output logic                     frame_done,
  output logic                     row_err,
  input  logic                     err_clr
);

  localparam int ROW_W = $clog2(ROWS);
  localparam int CNT_W = $clog2(COLS) + 1;
  localparam int P_SCLK = 7, P_LATCH = 6, P_BLANK = 5, P_ACLK = 4, P_ARST = 3;

  logic [7:0] pins, pin_lvl, pin_rise, pin_dly;
  logic       unused_pins;

  assign pins = {sclk_in, latch_in, blank_in, aclk_in, arst_in, red_in, green_in, blue_in};

  for (genvar i = 0; i < 8; i++) begin : g_sync
    led_pin_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
      .clk       (clk),
      .reset_n   (reset_n),
      .pin_in    (pins[i]),
      .level     (pin_lvl[i]),
      .rise      (pin_rise[i]),
      .level_dly (pin_dly[i])
    );
  end

  assign unused_pins = ^{pin_rise[2:0], pin_dly[7:3], pin_lvl[7:6], pin_lvl[4], pin_lvl[2:0]};

  state_t                  state_q, state_d;
  pixel_t [COLS-1:0]       shift_q, shift_d;
  pixel_t [COLS-1:0]       frame_q [ROWS];
  pixel_t [COLS-1:0]       frame_d [ROWS];
  logic   [CNT_W-1:0]      cnt_q, cnt_d;
  logic   [ROWS-1:0]       rows_seen_q, rows_seen_d;
  logic   [ROW_W-1:0]      cur_row_q, cur_row_d;
  logic                    row_err_q, row_err_d;
  logic                    frame_done_q, frame_done_d;
  logic                    lit_q, lit_d;
  pixel_t                  rd_pixel_q, rd_pixel_d;
  pixel_t                  setup_pix;

  // Data is taken one clk before the sclk rise so it is clear of the edge itself.
  assign setup_pix = pixel_t'(pin_dly[2:0]);

  always_comb begin
    state_d      = state_q;
    shift_d      = shift_q;
    cnt_d        = cnt_q;
    frame_d      = frame_q;
    rows_seen_d  = rows_seen_q;
    cur_row_d    = cur_row_q;
    row_err_d    = row_err_q & ~err_clr;
    frame_done_d = 1'b0;
    lit_d        = (state_q == RUN) & ~pin_lvl[P_BLANK];
    rd_pixel_d   = frame_q[rd_row][rd_col];

    if (state_q == RUN) begin
      if (pin_rise[P_SCLK]) begin
        shift_d = {shift_q[COLS-2:0], setup_pix};
        if (cnt_q != CNT_W'(COLS + 1)) cnt_d = cnt_q + CNT_W'(1);
      end
      if (pin_rise[P_LATCH]) begin
        frame_d[cur_row_q]     = shift_d;
        rows_seen_d[cur_row_q] = 1'b1;
        if (cnt_d != CNT_W'(COLS)) row_err_d = 1'b1;
        cnt_d = '0;
      end
    end

    if (pin_rise[P_ACLK]) begin
      cur_row_d = (cur_row_q == ROW_W'(ROWS - 1)) ? '0 : cur_row_q + ROW_W'(1);
    end

    if (pin_rise[P_ARST]) begin
      if (state_q == RUN) frame_done_d = &rows_seen_q;
      state_d     = RUN;
      rows_seen_d = '0;
    end

    // arst level dominates aclk, including the rise cycle.
    if (pin_lvl[P_ARST]) cur_row_d = '0;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= UNSYNC;
      shift_q      <= '0;
      frame_q      <= '{default: '0};
      cnt_q        <= '0;
      rows_seen_q  <= '0;
      cur_row_q    <= '0;
      row_err_q    <= 1'b0;
      frame_done_q <= 1'b0;
      lit_q        <= 1'b0;
      rd_pixel_q   <= '0;
    end else begin
      state_q      <= state_d;
      shift_q      <= shift_d;
      frame_q      <= frame_d;
      cnt_q        <= cnt_d;
      rows_seen_q  <= rows_seen_d;
      cur_row_q    <= cur_row_d;
      row_err_q    <= row_err_d;
      frame_done_q <= frame_done_d;
      lit_q        <= lit_d;
      rd_pixel_q   <= rd_pixel_d;
    end
  end

  assign rd_pixel   = rd_pixel_q;
  assign cur_row    = cur_row_q;
  assign lit        = lit_q;
  assign frame_done = frame_done_q;
  assign row_err    = row_err_q;

endmodule

// File: tb/tb_led_panel_sink.sv
// Directed bench for led_panel_sink: drives panel pins and checks frame store, row address and flags.
module tb_led_panel_sink;
  import led_panel_pkg::*;

  localparam int COLS = 32;
  localparam int ROWS = 4;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       sclk_in, latch_in, blank_in, aclk_in, arst_in;
  logic       red_in, green_in, blue_in;
  logic [1:0] rd_row;
  logic [4:0] rd_col;
  logic [2:0] rd_pixel;
  logic [1:0] cur_row;
  logic       lit, frame_done, row_err, err_clr;

  int n_tests = 0;
  int n_fail  = 0;
  int fd_cnt  = 0;
  int fd_base;

  logic [2:0] row_buf   [COLS];
  logic [2:0] exp_frame [ROWS][COLS];

  led_panel_sink #(.COLS(COLS), .ROWS(ROWS), .SYNC_STAGES(2)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .sclk_in    (sclk_in),
    .latch_in   (latch_in),
    .blank_in   (blank_in),
    .aclk_in    (aclk_in),
    .arst_in    (arst_in),
    .red_in     (red_in),
    .green_in   (green_in),
    .blue_in    (blue_in),
    .rd_row     (rd_row),
    .rd_col     (rd_col),
    .rd_pixel   (rd_pixel),
    .cur_row    (cur_row),
    .lit        (lit),
    .frame_done (frame_done),
    .row_err    (row_err),
    .err_clr    (err_clr)
  );

  always #5 clk = ~clk;

  // Counts high cycles of frame_done, so one pulse adds exactly 1.
  always @(negedge clk) if (frame_done) fd_cnt++;

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic send_pix(input logic [2:0] p);
    {red_in, green_in, blue_in} = p;
    sclk_in = 1'b0;
    cyc(2);
    sclk_in = 1'b1;
    cyc(2);
    sclk_in = 1'b0;
  endtask

  task automatic send_row_buf();
    for (int c = COLS - 1; c >= 0; c--) send_pix(row_buf[c]);
  endtask

  task automatic pulse_pins(input logic l, input logic a, input logic r);
    latch_in = l;
    aclk_in  = a;
    arst_in  = r;
    cyc(2);
    latch_in = 1'b0;
    aclk_in  = 1'b0;
    arst_in  = 1'b0;
    cyc(4);
  endtask

  task automatic rd_chk(input string tag, input int r, input int c, input logic [2:0] e);
    rd_row = r[1:0];
    rd_col = c[4:0];
    cyc(1);
    check(tag, rd_pixel, e);
  endtask

  initial begin
    {sclk_in, latch_in, blank_in, aclk_in, arst_in, red_in, green_in, blue_in} = '0;
    err_clr = 1'b0;
    rd_row  = '0;
    rd_col  = '0;
    reset_n = 1'b0;
    cyc(3);
    check("rst_rd_pixel", rd_pixel, 0);
    check("rst_cur_row", cur_row, 0);
    check("rst_lit", lit, 0);
    check("rst_frame_done", frame_done, 0);
    check("rst_row_err", row_err, 0);
    reset_n = 1'b1;
    cyc(2);

    // Full frame while UNSYNC: nothing captured, row address still tracked
    for (int c = 0; c < COLS; c++) row_buf[c] = 3'd7;
    for (int r = 0; r < ROWS; r++) begin
      send_row_buf();
      pulse_pins(1'b1, 1'b0, 1'b0);
      pulse_pins(1'b0, 1'b1, 1'b0);
      if (r == 0) check("unsync_cur_row", cur_row, 1);
    end
    check("unsync_wrap_row", cur_row, 0);
    check("unsync_lit", lit, 0);
    check("unsync_row_err", row_err, 0);
    check("unsync_no_done", fd_cnt, 0);
    rd_chk("unsync_rd_0_0", 0, 0, 3'd0);
    rd_chk("unsync_rd_2_31", 2, 31, 3'd0);
    rd_chk("unsync_rd_3_7", 3, 7, 3'd0);

    pulse_pins(1'b0, 1'b0, 1'b1);
    check("first_arst_no_done", fd_cnt, 0);
    check("run_lit", lit, 1);

    // Frame with pixel r+1 at column 0 of each row
    for (int r = 0; r < ROWS; r++) begin
      for (int c = 0; c < COLS; c++) row_buf[c] = 3'd0;
      row_buf[0] = 3'(r + 1);
      send_row_buf();
      pulse_pins(1'b1, 1'b0, 1'b0);
      pulse_pins(1'b0, 1'b1, 1'b0);
    end
    fd_base = fd_cnt;
    pulse_pins(1'b0, 1'b0, 1'b1);
    check("frame_done_once", fd_cnt - fd_base, 1);
    for (int r = 0; r < ROWS; r++) begin
      rd_chk($sformatf("col0_r%0d", r), r, 0, 3'(r + 1));
      rd_chk($sformatf("col5_r%0d", r), r, 5, 3'd0);
    end
    check("frame_row_err", row_err, 0);
    check("frame_cur_row", cur_row, 0);

    // aclk and arst together at row 2
    pulse_pins(1'b0, 1'b1, 1'b0);
    pulse_pins(1'b0, 1'b1, 1'b0);
    check("pre_simul_row", cur_row, 2);
    fd_base = fd_cnt;
    pulse_pins(1'b0, 1'b1, 1'b1);
    check("arst_wins_row", cur_row, 0);
    check("arst_empty_no_done", fd_cnt - fd_base, 0);

    // latch and aclk together at row 1
    pulse_pins(1'b0, 1'b1, 1'b0);
    for (int c = 0; c < COLS; c++) row_buf[c] = 3'($urandom_range(0, 7));
    send_row_buf();
    pulse_pins(1'b1, 1'b1, 1'b0);
    check("latch_aclk_row", cur_row, 2);
    rd_chk("latch_aclk_c0", 1, 0, row_buf[0]);
    rd_chk("latch_aclk_c13", 1, 13, row_buf[13]);
    rd_chk("latch_aclk_c31", 1, 31, row_buf[31]);
    rd_chk("row0_intact", 0, 0, 3'd1);
    check("latch_aclk_no_err", row_err, 0);

    // Short row, clear, long row
    for (int i = 0; i < 31; i++) send_pix(3'd0);
    pulse_pins(1'b1, 1'b0, 1'b0);
    check("short_row_err", row_err, 1);
    cyc(5);
    check("row_err_sticky", row_err, 1);
    err_clr = 1'b1;
    cyc(1);
    err_clr = 1'b0;
    check("err_clr", row_err, 0);
    for (int i = 0; i < 33; i++) send_pix(3'd0);
    pulse_pins(1'b1, 1'b0, 1'b0);
    check("long_row_err", row_err, 1);

    // Async reset part way through row 2
    rd_row = 2'd0;
    rd_col = 5'd0;
    for (int i = 0; i < 10; i++) send_pix(3'd5);
    @(posedge clk);
    #3;
    reset_n = 1'b0;
    #1;
    check("async_rd_pixel", rd_pixel, 0);
    check("async_cur_row", cur_row, 0);
    check("async_row_err", row_err, 0);
    check("async_lit", lit, 0);
    check("async_frame_done", frame_done, 0);
    cyc(2);
    reset_n = 1'b1;
    cyc(2);
    rd_chk("reset_clears_r0", 0, 0, 3'd0);
    rd_chk("reset_clears_r1", 1, 13, 3'd0);

    // Row sent before arst is discarded
    for (int c = 0; c < COLS; c++) row_buf[c] = 3'd6;
    send_row_buf();
    pulse_pins(1'b1, 1'b0, 1'b0);
    rd_chk("post_reset_unsync", 0, 4, 3'd0);
    check("post_reset_no_err", row_err, 0);

    // Random frame after arst, full scoreboard
    pulse_pins(1'b0, 1'b0, 1'b1);
    for (int r = 0; r < ROWS; r++) begin
      for (int c = 0; c < COLS; c++) begin
        row_buf[c]      = 3'($urandom_range(0, 7));
        exp_frame[r][c] = row_buf[c];
      end
      send_row_buf();
      pulse_pins(1'b1, 1'b0, 1'b0);
      pulse_pins(1'b0, 1'b1, 1'b0);
    end
    fd_base = fd_cnt;
    pulse_pins(1'b0, 1'b0, 1'b1);
    check("rand_frame_done", fd_cnt - fd_base, 1);
    check("rand_row_err", row_err, 0);
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++)
        rd_chk($sformatf("rand_r%0d_c%0d", r, c), r, c, exp_frame[r][c]);

    // lit tracks ~blank with SYNC_STAGES+1 latency
    check("lit_before_blank", lit, 1);
    blank_in = 1'b1;
    cyc(2);
    check("lit_blank_early", lit, 1);
    cyc(1);
    check("lit_blank_dark", lit, 0);
    blank_in = 1'b0;
    cyc(2);
    check("lit_unblank_early", lit, 0);
    cyc(1);
    check("lit_unblank", lit, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/led_panel_sink.md
# led_panel_sink

Receiving end of the HUB-style LED panel interface, and a synthesizable model of the panel itself. It oversamples the panel pins (sclk, latch, blank, aclk, arst, red/green/blue) in the system clock domain and shifts serial pixels into a row shift register. On each latch it commits the row into a frame store, and it tracks the row address from aclk/arst. It sits on the far side of the panel driver, for on-chip loopback checking and bench scoreboarding, and exposes the captured frame through a registered read port.

## Interface
- COLS, 32: sclk pulses per row (shift register depth)
- ROWS, 4: row addresses (aclk wraps modulo ROWS)
- SYNC_STAGES, 2: synchronizer flops per input pin (≥2)
- clk  in  1  system clock, all logic on rising edge
- reset_n  in  1  asynchronous, active-low reset
- sclk_in, latch_in, blank_in, aclk_in, arst_in  in  1 each  panel pins; latch_in active-high, blank_in high = dark
- red_in, green_in, blue_in  in  1 each  serial pixel data
- rd_row  in  clog2(ROWS)  read row address
- rd_col  in  clog2(COLS)  read column address
- rd_pixel  out  3  {r,g,b} at (rd_row, rd_col), registered
- cur_row  out  clog2(ROWS)  current panel row address
- lit  out  1  synchronized ~blank while state is RUN
- frame_done  out  1  one-cycle pulse at each frame boundary (arst)
- row_err  out  1  sticky: a latch arrived with shift count ≠ COLS
- err_clr  in  1  synchronous clear of row_err

## Operation
- All eight pins pass through SYNC_STAGES flops, then a 1-flop previous-value register. A rise is sync=1 and prev=0.
- Pixel capture: on an sclk rise, shift the {r,g,b} value held one clk before the rise (the setup value) into the shift register. After COLS shifts, the first pixel shifted is at column COLS-1 and the last at column 0.
- shift_cnt: width clog2(COLS)+1. Increments on each sclk rise, saturates at COLS+1, and clears on a latch rise.
- Latch rise:
  - frame[cur_row] <= shift register (post-shift content if an sclk rise occurs in the same cycle).
  - row_err set if shift_cnt ≠ COLS.
  - rows_seen bit [cur_row] set.
- aclk rise: cur_row <= cur_row+1 mod ROWS.
- arst rise (high level also holds cur_row=0):
  - cur_row <= 0.
  - frame_done pulses if all ROWS bits of rows_seen are set.
  - rows_seen clears.
- FSM states:
  - UNSYNC (reset state): shifts and latches are ignored and the frame is not written; cur_row still tracks aclk/arst. First arst rise → RUN (no frame_done pulse).
  - RUN: normal operation; stays in RUN until reset.
- Simultaneous events:
  - arst rise + aclk rise: arst wins, cur_row=0.
  - latch rise + aclk rise: write to the old row, then increment.
  - err_clr + error set in the same cycle: set wins.
- Reset values: rd_pixel=0, cur_row=0, lit=0, frame_done=0, row_err=0, frame store=0, shift register=0, shift_cnt=0, rows_seen=0, state=UNSYNC, synchronizers=0.
- Reset mid-row: everything returns to the reset values. A partial row is discarded. Capture resumes only after the next arst rise.

## Timing
- Pin edge to detect: SYNC_STAGES+1 clk. An edge at the pins lands in state at SYNC_STAGES+1 cycles after the first sampling edge.
- sclk high and low phases must each last ≥2 clk. Data must be stable ≥2 clk before the sclk rise. Faster input is unsupported; behaviour is undefined but must not lock up.
- Frame store write: same cycle as the latch-rise detect. A read of that row sees new data on rd_pixel 2 cycles after detect (store write, then registered read).
- rd_pixel latency: 1 clk from rd_row/rd_col.
- frame_done: asserted the cycle after the arst-rise detect, for exactly 1 clk.
- lit follows synchronized blank with the same SYNC_STAGES+1 latency.

## Structure
- Package led_panel_pkg holds:
  - COLS_DEF=32, ROWS_DEF=4.
  - The 3-bit pixel typedef ordered {red, green, blue}.
  - FSM state enum {UNSYNC, RUN}.
- Sub-module led_pin_sync: one instance per pin. Parameter SYNC_STAGES; outputs level, rise and the 1-clk-delayed level (the delayed level is used for data setup capture).
- Frame store: flop array of ROWS×COLS×3 (384 bits at the defaults). It has one write port (a whole row) and one registered read port.

## Test plan
- Reset, then arst pulse, then per row r∈0..3: 32 sclk pulses with pixel = r+1 at col 0 only and black elsewhere, then latch, then aclk. Then arst → frame_done pulses once; rd(r,0)=r+1; rd(r,5)=0; row_err=0.
- 31 sclk pulses then latch → row_err=1 and stays 1. Assert err_clr → 0. Next latch after 33 pulses → row_err=1 again.
- Full frame sent before any arst (state UNSYNC) → frame store all zeros and no frame_done. After one arst, a second frame is captured.
- aclk and arst rising in the same clk with cur_row=2 → cur_row=0. Latch and aclk together at row 1 → row 1 written, cur_row=2.
- reset_n asserted after 10 of 32 shifts in row 2 → all outputs at their reset values immediately (async). A frame after the next arst is captured cleanly.
- blank_in toggles in RUN → lit = ~blank after SYNC_STAGES+1 clk. With sclk high/low = 2 clk and data changed at the sclk fall, every pixel is captured correctly (checked with a random-frame scoreboard).
